mag_sar_search: RTL

MAG_SAR_SEARCH -- requirements
Module: mag_sar_search

---
 rtl/mag_sar_if.sv | 24 ++
 rtl/mag_sar_search.sv | 103 ++++++++++
 2 files changed

// File: rtl/mag_sar_if.sv
// Bundle between the SAR search controller and its host/comparator:
// start request, comparator probe/response and search status.
interface mag_sar_if;
    logic       start;
    logic [3:0] probe;
    logic       eq_in;
    logic       gt_in;
    logic       lt_in;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       error;

    modport master (
        output start, eq_in, gt_in, lt_in,
        input  probe, busy, done, result, found, error
    );

    modport slave (
        input  start, eq_in, gt_in, lt_in,
        output probe, busy, done, result, found, error
    );
endinterface

// File: rtl/mag_sar_search.sv
// 4-bit successive-approximation search driving an external magnitude comparator.
// state | meaning: IDLE wait for start | PROBE trial bit k | VERIFY confirm acc | DONE one-cycle completion
module mag_sar_search (
    input  logic        clk,
    input  logic        rst_n,
    mag_sar_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, PROBE, VERIFY, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] result_q, result_d;
    logic       found_q, found_d;
    logic       error_q, error_d;
    logic [3:0] probe_w;
    logic       legal;

    always_comb begin
        legal = $onehot({bus.eq_in, bus.gt_in, bus.lt_in});
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        found_d  = found_q;
        error_d  = error_q;
        probe_w  = 4'd0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = PROBE;
                    k_d     = 2'd3;
                    acc_d   = 4'd0;
                    found_d = 1'b0;
                    error_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            PROBE: begin
                probe_w = acc_q | (4'b0001 << k_q);
                if (!legal) begin
                    result_d = acc_q;
                    found_d  = 1'b0;
                    error_d  = 1'b1;
                    state_d  = DONE;
                end else if (bus.eq_in) begin
                    result_d = probe_w;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    if (bus.gt_in) begin
                        acc_d = probe_w;
                    end
                    k_d = k_q - 2'd1;
                    if (k_q == 2'd0) begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                probe_w  = acc_q;
                result_d = acc_q;
                state_d  = DONE;
                if (!legal) begin
                    found_d = 1'b0;
                    error_d = 1'b1;
                end else begin
                    found_d = bus.eq_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= 2'd3;
            acc_q    <= 4'd0;
            result_q <= 4'd0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign bus.probe  = probe_w;
    assign bus.busy   = (state_q == PROBE) || (state_q == VERIFY);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.error  = error_q;
endmodule
